lab_dp: RTL and testbench

- 8-bit accumulator datapath driven directly by the control unit's outputs (IRload, JMPmux, PCload, Meminst, MemWr, Asel, Aload, Sub).
- Holds PC, IR, the A register, a 32x8 synchronous-read RAM, and the add/sub unit.
- Returns IR opcode, Aeq0 and Apos to the control unit.
- A host program-load port fills RAM before a run.

---
 rtl/lab_dp.sv | 138 +++++++++++++
 tb/tb_lab_dp.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/lab_dp.sv
// lab_dp: accumulator-machine datapath.
// Holds PC, IR, the A accumulator, a 32x8 synchronous-read RAM and an add/sub unit.
// The control unit drives the strobes. The datapath returns the opcode and the
// sign/zero flags of A. A host port can own the RAM to load or read back programs.
// The opcode width DATA_W-ADDR_W is expected to be 3.
module lab_dp #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     IRload,
  input  logic                     JMPmux,
  input  logic                     PCload,
  input  logic                     Meminst,
  input  logic                     MemWr,
  input  logic [1:0]               Asel,
  input  logic                     Aload,
  input  logic                     Sub,
  input  logic                     Halt,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     prog_en,
  input  logic                     prog_we,
  input  logic [ADDR_W-1:0]        prog_addr,
  input  logic [DATA_W-1:0]        prog_data,
  output logic [DATA_W-ADDR_W-1:0] IR,
  output logic                     Aeq0,
  output logic                     Apos,
  output logic [DATA_W-1:0]        A_out,
  output logic [ADDR_W-1:0]        PC_out,
  output logic [DATA_W-1:0]        mem_q
);

  localparam int DEPTH = 1 << ADDR_W;

  // Encodings of the A source select.
  typedef enum logic [1:0] {
    A_SRC_ALU  = 2'b00,
    A_SRC_IN   = 2'b01,
    A_SRC_MEM  = 2'b10,
    A_SRC_ZERO = 2'b11
  } a_src_e;

  // Architectural registers.
  logic [ADDR_W-1:0] pc_q;
  logic [DATA_W-1:0] ir_q;
  logic [DATA_W-1:0] a_q;

  // RAM storage and port signals.
  logic [DATA_W-1:0] ram [DEPTH];
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [DATA_W-1:0] ram_wdata;

  // Next-state values.
  logic              cpu_en;
  logic [ADDR_W-1:0] pc_next;
  logic [DATA_W-1:0] alu_res;
  logic [DATA_W-1:0] a_next;
  a_src_e            a_src;

  // The CPU may change state only when the host does not own the RAM and the machine is not halted.
  assign cpu_en = ~prog_en & ~Halt;
  assign a_src  = a_src_e'(Asel);

  // RAM port mux: the host port wins over the CPU, and a CPU write under host ownership is dropped.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can leave it unassigned and infer a latch.
    ram_addr  = pc_q;
    ram_we    = 1'b0;
    ram_wdata = a_q;
    if (prog_en) begin
      ram_addr  = prog_addr;
      ram_we    = prog_we;
      ram_wdata = prog_data;
    end else begin
      ram_addr  = Meminst ? ir_q[ADDR_W-1:0] : pc_q;
      ram_we    = MemWr & ~Halt;
      ram_wdata = a_q;
    end
  end

  // Add/sub unit. The result wraps modulo 2^DATA_W with no carry or overflow flag.
  always_comb begin
    alu_res = Sub ? (a_q - mem_q) : (a_q + mem_q);
  end

  // PC source: sequential increment, wrapping at the top, or the jump target in the IR operand field.
  always_comb begin
    pc_next = JMPmux ? ir_q[ADDR_W-1:0] : (pc_q + ADDR_W'(1));
  end

  // A source select.
  always_comb begin
    a_next = '0;
    case (a_src)
      A_SRC_ALU:  a_next = alu_res;
      A_SRC_IN:   a_next = in_data;
      A_SRC_MEM:  a_next = mem_q;
      A_SRC_ZERO: a_next = '0;
      default:    a_next = '0;
    endcase
  end

  // PC, IR and A: load on their strobes while the CPU is enabled.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc_q <= '0;
      ir_q <= '0;
      a_q  <= '0;
    end else if (cpu_en) begin
      // NOTE: state uses non-blocking assignments so every register samples pre-edge values, whatever the statement order.
      if (PCload) pc_q <= pc_next;
      if (IRload) ir_q <= mem_q;
      if (Aload)  a_q  <= a_next;
    end
  end

  // RAM write port. The contents survive reset so a loaded program is kept.
  always_ff @(posedge clock) begin
    // NOTE: the memory array has no reset; this lets it map onto RAM macros, and program contents must persist.
    if (ram_we) ram[ram_addr] <= ram_wdata;
  end

  // Synchronous read register. It sees the pre-write contents on a same-address read-during-write.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) mem_q <= '0;
    else        mem_q <= ram[ram_addr];
  end

  // Status and display outputs, taken from the A register only and never from the ALU.
  assign IR     = ir_q[DATA_W-1:ADDR_W];
  assign Aeq0   = (a_q == '0);
  assign Apos   = ~a_q[DATA_W-1];
  assign A_out  = a_q;
  assign PC_out = pc_q;

endmodule

// File: tb/tb_lab_dp.sv
// Testbench for lab_dp: directed control sequences with hand-computed checks.
// A behavioural machine model is compared against the DUT on every clock.
module tb_lab_dp;

  logic       clock = 1'b0;
  logic       reset;
  logic       IRload, JMPmux, PCload, Meminst, MemWr, Aload, Sub, Halt;
  logic [1:0] Asel;
  logic [7:0] in_data;
  logic       prog_en, prog_we;
  logic [4:0] prog_addr;
  logic [7:0] prog_data;
  logic [2:0] IR;
  logic       Aeq0, Apos;
  logic [7:0] A_out;
  logic [4:0] PC_out;
  logic [7:0] mem_q;

  int checks   = 0;
  int failures = 0;

  lab_dp dut (
    .clock(clock), .reset(reset), .IRload(IRload), .JMPmux(JMPmux), .PCload(PCload),
    .Meminst(Meminst), .MemWr(MemWr), .Asel(Asel), .Aload(Aload), .Sub(Sub), .Halt(Halt),
    .in_data(in_data), .prog_en(prog_en), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .IR(IR), .Aeq0(Aeq0), .Apos(Apos), .A_out(A_out),
    .PC_out(PC_out), .mem_q(mem_q)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // The machine state is written as plain variables. RAM words are tracked as known or unknown.
  logic [4:0] m_pc = '0;
  logic [7:0] m_ir = '0, m_a = '0, m_q = '0;
  logic [7:0] m_ram [32];
  logic [31:0] m_known = '0;
  logic        m_q_known = 1'b1;

  wire       m_run  = !prog_en && !Halt;
  wire [4:0] m_addr = prog_en ? prog_addr : (Meminst ? m_ir[4:0] : m_pc);
  wire       m_we   = prog_en ? prog_we : (MemWr && !Halt);
  wire [7:0] m_wd   = prog_en ? prog_data : m_a;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_pc <= '0; m_ir <= '0; m_a <= '0; m_q <= '0; m_q_known <= 1'b1;
    end else begin
      m_q       <= m_ram[m_addr];
      m_q_known <= m_known[m_addr];
      if (m_we) begin
        m_ram[m_addr]   <= m_wd;
        m_known[m_addr] <= 1'b1;
      end
      if (m_run) begin
        if (IRload) m_ir <= m_q;
        if (PCload) m_pc <= JMPmux ? m_ir[4:0] : 5'((m_pc + 1) % 32);
        if (Aload) begin
          case (Asel)
            2'd0: m_a <= Sub ? 8'((int'(m_a) - int'(m_q)) % 256) : 8'((int'(m_a) + int'(m_q)) % 256);
            2'd1: m_a <= in_data;
            2'd2: m_a <= m_q;
            default: m_a <= 8'd0;
          endcase
        end
      end
    end
  end

  // Per-cycle comparison against the model while out of reset.
  always @(posedge clock) begin
    #1;
    if (reset === 1'b1) begin
      check("cyc_A", A_out, m_a);
      check("cyc_PC", PC_out, m_pc);
      check("cyc_IR", IR, m_ir[7:5]);
      check("cyc_Aeq0", Aeq0, (m_a == 0));
      check("cyc_Apos", Apos, (m_a < 128));
      if (m_q_known) check("cyc_mem_q", mem_q, m_q);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic begin_cycle();
    @(negedge clock);
    IRload = 0; JMPmux = 0; PCload = 0; Meminst = 0; MemWr = 0; Asel = 2'd0;
    Aload = 0; Sub = 0; Halt = 0; in_data = 8'h00; prog_en = 0; prog_we = 0;
    prog_addr = '0; prog_data = '0;
  endtask

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic host_write(input logic [4:0] a, input logic [7:0] d);
    begin_cycle(); prog_en = 1; prog_we = 1; prog_addr = a; prog_data = d; step();
  endtask

  task automatic host_read(input logic [4:0] a);
    begin_cycle(); prog_en = 1; prog_addr = a; step();
  endtask

  // Fetch: read RAM[PC], then load IR and increment PC.
  task automatic fetch();
    begin_cycle(); step();
    begin_cycle(); IRload = 1; PCload = 1; step();
  endtask

  task automatic set_a(input logic [7:0] v);
    begin_cycle(); Asel = 2'd1; in_data = v; Aload = 1; step();
  endtask

  initial begin
    reset = 0;
    IRload = 0; JMPmux = 0; PCload = 0; Meminst = 0; MemWr = 0; Asel = 2'd0;
    Aload = 0; Sub = 0; Halt = 0; in_data = 8'h00; prog_en = 0; prog_we = 0;
    prog_addr = '0; prog_data = '0;
    repeat (2) @(posedge clock);
    #2;
    check("rst_A", A_out, 8'h00);
    check("rst_PC", PC_out, 5'd0);
    check("rst_IR", IR, 3'b000);
    check("rst_Aeq0", Aeq0, 1'b1);
    check("rst_Apos", Apos, 1'b1);
    check("rst_mem_q", mem_q, 8'h00);
    @(negedge clock);
    reset = 1;

    // 1: LOAD 30, ADD 31, STORE 29, HALT
    host_write(5'd0, 8'h1E); host_write(5'd1, 8'h5F); host_write(5'd2, 8'h3D);
    host_write(5'd3, 8'hE0); host_write(5'd30, 8'h05); host_write(5'd31, 8'h07);
    fetch();
    begin_cycle(); Meminst = 1; step();
    begin_cycle(); Asel = 2'd2; Aload = 1; step();
    check("t1_load_A", A_out, 8'd5);
    fetch();
    begin_cycle(); Meminst = 1; step();
    begin_cycle(); Asel = 2'd0; Aload = 1; step();
    check("t1_add_A", A_out, 8'd12);
    fetch();
    begin_cycle(); Meminst = 1; MemWr = 1; step();
    fetch();
    begin_cycle(); Halt = 1; step();
    check("t1_A", A_out, 8'd12);
    check("t1_PC", PC_out, 5'd4);
    check("t1_IR", IR, 3'b111);
    host_read(5'd29);
    check("t1_ram29", mem_q, 8'h0C);

    // 2: subtraction wrap and positive overflow into the sign bit
    set_a(8'd3);
    host_read(5'd30);
    begin_cycle(); Asel = 2'd0; Sub = 1; Aload = 1; step();
    check("t2_sub_A", A_out, 8'hFE);
    check("t2_sub_Aeq0", Aeq0, 1'b0);
    check("t2_sub_Apos", Apos, 1'b0);
    host_write(5'd28, 8'h01);
    set_a(8'h7F);
    check("t2_7f_Apos", Apos, 1'b1);
    host_read(5'd28);
    begin_cycle(); Asel = 2'd0; Aload = 1; step();
    check("t2_add_A", A_out, 8'h80);
    check("t2_add_Apos", Apos, 1'b0);

    // 3: JZ 7 -- a jump select without PCload is a no-op, then the jump itself
    host_write(5'd27, 8'hA7);
    host_read(5'd27);
    begin_cycle(); IRload = 1; step();
    check("t3_IR", IR, 3'b101);
    begin_cycle(); JMPmux = 1; step();
    check("t3_nojump_PC", PC_out, 5'd4);
    begin_cycle(); JMPmux = 1; PCload = 1; step();
    check("t3_jump_PC", PC_out, 5'd7);

    // 4: PC wrap, input load, zero load
    host_write(5'd26, 8'h1F);
    host_read(5'd26);
    begin_cycle(); IRload = 1; step();
    begin_cycle(); JMPmux = 1; PCload = 1; step();
    check("t4_PC31", PC_out, 5'd31);
    begin_cycle(); PCload = 1; step();
    check("t4_wrap_PC", PC_out, 5'd0);
    set_a(8'h5A);
    check("t4_in_A", A_out, 8'h5A);
    begin_cycle(); Asel = 2'd3; Aload = 1; step();
    check("t4_zero_A", A_out, 8'h00);
    check("t4_zero_Aeq0", Aeq0, 1'b1);

    // 5: host ownership drops CPU writes; Halt freezes state
    set_a(8'h5A);
    begin_cycle(); prog_en = 1; prog_addr = 5'd31; MemWr = 1; Meminst = 1; Aload = 1; step();
    check("t5_prog_A", A_out, 8'h5A);
    begin_cycle(); step();
    host_read(5'd31);
    check("t5_ram31", mem_q, 8'h07);
    begin_cycle(); Halt = 1; MemWr = 1; Meminst = 1; Aload = 1; Asel = 2'd1; in_data = 8'h33; PCload = 1; step();
    check("t5_halt_A", A_out, 8'h5A);
    check("t5_halt_PC", PC_out, 5'd0);
    check("t5_halt_mem_q", mem_q, 8'h07);
    host_read(5'd31);
    check("t5_halt_ram31", mem_q, 8'h07);

    // 6: asynchronous reset during an ADD execute cycle
    host_read(5'd27);
    begin_cycle(); IRload = 1; step();
    begin_cycle(); JMPmux = 1; PCload = 1; step();
    host_read(5'd30);
    begin_cycle(); Asel = 2'd0; Aload = 1;
    #2 reset = 0;
    #1;
    check("t6_A", A_out, 8'h00);
    check("t6_PC", PC_out, 5'd0);
    check("t6_IR", IR, 3'b000);
    check("t6_Aeq0", Aeq0, 1'b1);
    check("t6_mem_q", mem_q, 8'h00);
    @(negedge clock);
    reset = 1;
    host_read(5'd30);
    check("t6_ram30", mem_q, 8'h05);

    repeat (2) @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
